lc4_perf_monitor: RTL and testbench

//   Synthesisable performance/termination monitor for the scalar lc4_processor.

---
 rtl/lc4_perf_monitor.sv | 106 ++++++++++
 tb/tb_lc4_perf_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lc4_perf_monitor.sv
// Performance/termination monitor for lc4_processor: counts observed cycles per stall
// class, detects halt or cycle-limit timeout, and exposes counters via a registered read port.
module lc4_perf_monitor #(
   parameter int                 INSN_W     = 20,
   parameter int                 STALL_W    = 2,
   parameter int                 CNT_W      = 32,
   parameter logic [INSN_W-1:0]  HALT_INSN  = 20'h88000,
   parameter int                 MAX_CYCLES = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               gwe,
   input  logic               i_start,
   input  logic               i_clear,
   input  logic [STALL_W-1:0] i_stall,
   input  logic [INSN_W-1:0]  i_insn,
   input  logic               i_rd_en,
   input  logic [STALL_W:0]   i_rd_sel,
   output logic               o_rd_valid,
   output logic [CNT_W-1:0]   o_rd_data,
   output logic [1:0]         o_state,
   output logic               o_done,
   output logic               o_saturated
);

   localparam int               NUM_CLASSES = 2**STALL_W;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] MAX_C       = CNT_W'(MAX_CYCLES);
   localparam logic [STALL_W:0] NUM_SEL     = (STALL_W+1)'(NUM_CLASSES);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2, S_TIMEOUT = 2'd3} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cycles;
   logic [CNT_W-1:0] r_class [NUM_CLASSES];
   logic             r_saturated;
   logic             r_rd_vld_p1;
   logic [CNT_W-1:0] r_rd_data_p1;

   logic             w_obs;
   logic             w_halt;
   logic             w_tmo;
   logic             w_restart;
   logic [CNT_W-1:0] w_cyc_next;
   logic [CNT_W-1:0] w_cls_next;
   logic [STALL_W:0] w_sel_m1;
   logic [CNT_W-1:0] w_rd_mux;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   assign w_obs      = gwe && (r_state == S_RUN);
   assign w_cyc_next = sat_inc(r_cycles);
   assign w_cls_next = sat_inc(r_class[i_stall]);
   assign w_halt     = w_obs && (i_stall == '0) && (i_insn == HALT_INSN);
   assign w_tmo      = w_obs && (MAX_CYCLES != 0) && (w_cyc_next == MAX_C);
   assign w_restart  = i_start && (r_state != S_RUN);

   // Control and counters: clear beats start, start beats counting, halt beats timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cycles    <= '0;
         r_saturated <= 1'b0;
         for (int i = 0; i < NUM_CLASSES; i++) r_class[i] <= '0;
      end else if (i_clear || w_restart) begin
         r_state     <= i_clear ? S_IDLE : S_RUN;
         r_cycles    <= '0;
         r_saturated <= 1'b0;
         for (int i = 0; i < NUM_CLASSES; i++) r_class[i] <= '0;
      end else if (w_obs) begin
         r_cycles         <= w_cyc_next;
         r_class[i_stall] <= w_cls_next;
         if (w_cyc_next == CNT_MAX || w_cls_next == CNT_MAX) r_saturated <= 1'b1;
         if (w_halt)     r_state <= S_HALTED;
         else if (w_tmo) r_state <= S_TIMEOUT;
      end
   end

   assign w_sel_m1 = i_rd_sel - 1'b1;

   always_comb begin
      w_rd_mux = '0;
      if (i_rd_sel == '0)           w_rd_mux = r_cycles;
      else if (i_rd_sel <= NUM_SEL) w_rd_mux = r_class[w_sel_m1[STALL_W-1:0]];
   end

   // Read stage p1: captures pre-update counter values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_vld_p1  <= 1'b0;
         r_rd_data_p1 <= '0;
      end else begin
         r_rd_vld_p1 <= i_rd_en;
         if (i_rd_en) r_rd_data_p1 <= w_rd_mux;
      end
   end

   assign o_rd_valid  = r_rd_vld_p1;
   assign o_rd_data   = r_rd_data_p1;
   assign o_state     = r_state;
   assign o_done      = (r_state == S_HALTED) || (r_state == S_TIMEOUT);
   assign o_saturated = r_saturated;

endmodule

// File: tb/tb_lc4_perf_monitor.sv
// Directed bench: three monitors share stimulus (default, MAX_CYCLES=8, CNT_W=3).
module tb_lc4_perf_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        gwe;
   logic        i_start;
   logic        i_clear;
   logic [1:0]  i_stall;
   logic [19:0] i_insn;
   logic        i_rd_en;
   logic [2:0]  i_rd_sel;

   logic        a_vld, b_vld, c_vld;
   logic [31:0] a_data, b_data;
   logic [2:0]  c_data;
   logic [1:0]  a_state, b_state, c_state;
   logic        a_done, b_done, c_done;
   logic        a_sat, b_sat, c_sat;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   lc4_perf_monitor u_a (
      .clk(clk), .rst(rst), .gwe(gwe), .i_start(i_start), .i_clear(i_clear),
      .i_stall(i_stall), .i_insn(i_insn), .i_rd_en(i_rd_en), .i_rd_sel(i_rd_sel),
      .o_rd_valid(a_vld), .o_rd_data(a_data), .o_state(a_state), .o_done(a_done),
      .o_saturated(a_sat));

   lc4_perf_monitor #(.MAX_CYCLES(8)) u_b (
      .clk(clk), .rst(rst), .gwe(gwe), .i_start(i_start), .i_clear(i_clear),
      .i_stall(i_stall), .i_insn(i_insn), .i_rd_en(i_rd_en), .i_rd_sel(i_rd_sel),
      .o_rd_valid(b_vld), .o_rd_data(b_data), .o_state(b_state), .o_done(b_done),
      .o_saturated(b_sat));

   lc4_perf_monitor #(.CNT_W(3)) u_c (
      .clk(clk), .rst(rst), .gwe(gwe), .i_start(i_start), .i_clear(i_clear),
      .i_stall(i_stall), .i_insn(i_insn), .i_rd_en(i_rd_en), .i_rd_sel(i_rd_sel),
      .o_rd_valid(c_vld), .o_rd_data(c_data), .o_state(c_state), .o_done(c_done),
      .o_saturated(c_sat));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic obs(input logic [1:0] stall, input logic [19:0] insn);
      gwe = 1'b1; i_stall = stall; i_insn = insn;
      step();
      gwe = 1'b0; i_stall = 2'd0; i_insn = 20'h0;
   endtask

   task automatic rd(input logic [2:0] sel);
      i_rd_en = 1'b1; i_rd_sel = sel;
      step();
      i_rd_en = 1'b0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic pulse_clear();
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; gwe = 1'b0; i_start = 1'b0; i_clear = 1'b0;
      i_stall = 2'd0; i_insn = 20'h0; i_rd_en = 1'b0; i_rd_sel = 3'd0;
      step(); step();
      chk("rst_state", 32'(a_state), 32'd0);
      chk("rst_done",  32'(a_done), 32'd0);
      chk("rst_sat",   32'(a_sat), 32'd0);
      chk("rst_vld",   32'(a_vld), 32'd0);
      chk("rst_data",  a_data, 32'd0);
      rst = 1'b0;
      step();
      chk("idle_nocount_state", 32'(a_state), 32'd0);

      // Test 1: stall sequence 0,0,2,3,0 with an unobserved gwe=0 cycle inserted
      pulse_start();
      chk("t1_run", 32'(a_state), 32'd1);
      obs(2'd0, 20'h0); obs(2'd0, 20'h0);
      i_stall = 2'd1; step(); i_stall = 2'd0;
      obs(2'd2, 20'h0); obs(2'd3, 20'h0); obs(2'd0, 20'h0);
      rd(3'd0); chk("t1_cycles", a_data, 32'd5); chk("t1_vld", 32'(a_vld), 32'd1);
      step();   chk("t1_vld_pulse", 32'(a_vld), 32'd0);
      rd(3'd1); chk("t1_class0", a_data, 32'd3);
      rd(3'd2); chk("t1_class1", a_data, 32'd0);
      rd(3'd3); chk("t1_class2", a_data, 32'd1);
      rd(3'd4); chk("t1_class3", a_data, 32'd1);
      chk("t1_state", 32'(a_state), 32'd1);

      // Test 2: halt instruction is counted, then counting stops
      obs(2'd0, 20'h88000);
      chk("t2_state", 32'(a_state), 32'd2);
      chk("t2_done",  32'(a_done), 32'd1);
      obs(2'd0, 20'h0); obs(2'd1, 20'h0);
      rd(3'd0); chk("t2_cycles", a_data, 32'd6);
      rd(3'd1); chk("t2_class0", a_data, 32'd4);
      rd(3'd2); chk("t2_class1", a_data, 32'd0);

      // Test 3 + 5: timeout at 8 on u_b, saturation at 7 on u_c
      pulse_start();
      chk("t3_restart", 32'(a_state), 32'd1);
      for (int i = 0; i < 7; i++) obs(2'd1, 20'h0);
      chk("t3_b_run7", 32'(b_state), 32'd1);
      obs(2'd1, 20'h0);
      chk("t3_b_timeout", 32'(b_state), 32'd3);
      chk("t3_b_done",    32'(b_done), 32'd1);
      chk("t3_a_run",     32'(a_state), 32'd1);
      obs(2'd1, 20'h0);
      rd(3'd0);
      chk("t3_b_cycles", b_data, 32'd8);
      chk("t3_a_cycles", a_data, 32'd9);
      chk("t5_c_cycles", 32'(c_data), 32'd7);
      rd(3'd2);
      chk("t5_c_class1", 32'(c_data), 32'd7);
      chk("t5_c_sat", 32'(c_sat), 32'd1);
      chk("t5_a_nosat", 32'(a_sat), 32'd0);

      // Clear together with start: clear wins
      i_clear = 1'b1; i_start = 1'b1;
      step();
      i_clear = 1'b0; i_start = 1'b0;
      chk("clr_state", 32'(a_state), 32'd0);
      chk("clr_c_sat", 32'(c_sat), 32'd0);
      rd(3'd0); chk("clr_cycles", a_data, 32'd0);
      rd(3'd2); chk("clr_class1", a_data, 32'd0);

      // Test 4: halt and timeout on the same cycle -> HALTED; start ignored in RUN
      pulse_start();
      for (int i = 0; i < 4; i++) obs(2'd0, 20'h0);
      pulse_start();
      for (int i = 0; i < 3; i++) obs(2'd0, 20'h0);
      obs(2'd0, 20'h88000);
      chk("t4_b_halted", 32'(b_state), 32'd2);
      rd(3'd0);
      chk("t4_b_cycles", b_data, 32'd8);
      chk("t4_a_cycles", a_data, 32'd8);

      // Test 6: read concurrent with increment, back-to-back reads, out-of-range select
      pulse_clear();
      pulse_start();
      for (int i = 0; i < 4; i++) obs(2'd0, 20'h0);
      gwe = 1'b1; i_stall = 2'd0; i_rd_en = 1'b1; i_rd_sel = 3'd0;
      step();
      gwe = 1'b0;
      chk("t6_pre_inc", a_data, 32'd4);
      i_rd_sel = 3'd0; step(); chk("t6_post_inc", a_data, 32'd5);
      i_rd_sel = 3'd1; step(); chk("t6_b2b_class0", a_data, 32'd5);
      chk("t6_b2b_vld", 32'(a_vld), 32'd1);
      i_rd_sel = 3'd7; step(); chk("t6_sel7_data", a_data, 32'd0);
      chk("t6_sel7_vld", 32'(a_vld), 32'd1);
      i_rd_sel = 3'd0; i_clear = 1'b1; i_start = 1'b1;
      step();
      i_rd_en = 1'b0; i_clear = 1'b0; i_start = 1'b0;
      chk("t6_rd_preclear", a_data, 32'd5);
      chk("t6_clr_state", 32'(a_state), 32'd0);
      rd(3'd0); chk("t6_clr_cycles", a_data, 32'd0);

      // Async reset mid-run
      pulse_start();
      obs(2'd2, 20'h0); obs(2'd2, 20'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_state", 32'(a_state), 32'd0);
      chk("arst_data",  a_data, 32'd0);
      step();
      rst = 1'b0;
      rd(3'd3); chk("arst_class2", a_data, 32'd0);
      rd(3'd0); chk("arst_cycles", a_data, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
